// File: rtl/cv32e40p_lce_detector.sv
// cv32e40p_lce_detector
//
// Watches the instruction stream leaving the marker-insertion stage and
// raises a sticky alarm when too many counted instructions pass without a
// security marker (JAL x0,0 = 32'h0000006f) between them. All-zero words
// are treated as bubbles and neither count nor reset the gap counter.
//
// Parameters:
//   WWDL           maximum consecutive counted instructions between markers
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   enable_i       monitoring enable
//   instr_valid_i  instr_i is valid this cycle
//   instr_i        32-bit instruction word
//   flush_i        pipeline flush, clears the gap counter while monitoring
//   alarm_clr_i    acknowledge that releases a raised alarm
//   alarm_o        registered alarm, high exactly while in ALARM
//   state_o        FSM state (IDLE=0, MON=1, ALARM=2)
//   marker_cnt_o   markers accepted while monitoring (stats build only)
//   alarm_cnt_o    MON->ALARM transitions (stats build only)
//
// Optional feature macro: CV32E40P_LCE_STATS_EN enables the saturating
// statistics counters; without it both counter outputs are tied to zero.

module cv32e40p_lce_detector #(
  parameter int WWDL = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic        flush_i,
  input  logic        alarm_clr_i,
  output logic        alarm_o,
  output logic [1:0]  state_o,
  output logic [15:0] marker_cnt_o,
  output logic [7:0]  alarm_cnt_o
);

  localparam int CW = $clog2(WWDL + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WWDL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MON   = 2'd1,
    ALARM = 2'd2
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          alarm_q;
  logic          is_marker, is_ignored;

  assign is_marker  = (instr_i == 32'h0000006f);
  assign is_ignored = (instr_i == 32'h00000000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      alarm_q <= (state_n == ALARM);
    end
  end

  // Disable wins over everything in MON, then flush, then the instruction.
  // A counted instruction arriving with the counter already at WWDL is the
  // violation; the counter stays saturated so it never exceeds WWDL.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (enable_i) state_n = MON;
      end
      MON: begin
        if (!enable_i) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (flush_i) begin
          cnt_n = '0;
        end else if (instr_valid_i) begin
          if (is_marker) begin
            cnt_n = '0;
          end else if (!is_ignored) begin
            if (cnt_q == CNT_MAX) begin
              state_n = ALARM;
            end else begin
              cnt_n = cnt_q + CW'(1);
            end
          end
        end
      end
      ALARM: begin
        if (alarm_clr_i) begin
          cnt_n   = '0;
          state_n = enable_i ? MON : IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    alarm_o = alarm_q;
    state_o = state_q;
  end

`ifdef CV32E40P_LCE_STATS_EN
  logic        marker_acc;
  logic        alarm_rise;
  logic [15:0] marker_cnt_q;
  logic [7:0]  alarm_cnt_q;

  // Mirrors the MON branch above: only a marker that actually resets the
  // gap counter is counted.
  assign marker_acc = (state_q == MON) && enable_i && !flush_i &&
                      instr_valid_i && is_marker;
  assign alarm_rise = (state_q == MON) && (state_n == ALARM);

  always_ff @(posedge clk) begin
    if (rst) begin
      marker_cnt_q <= '0;
      alarm_cnt_q  <= '0;
    end else begin
      if (marker_acc && (marker_cnt_q != 16'hFFFF))
        marker_cnt_q <= marker_cnt_q + 16'd1;
      if (alarm_rise && (alarm_cnt_q != 8'hFF))
        alarm_cnt_q <= alarm_cnt_q + 8'd1;
    end
  end

  assign marker_cnt_o = marker_cnt_q;
  assign alarm_cnt_o  = alarm_cnt_q;
`else
  assign marker_cnt_o = '0;
  assign alarm_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_lce_detector.sv
// Directed testbench for cv32e40p_lce_detector (WWDL = 8). Expected values
// for the statistics outputs follow the CV32E40P_LCE_STATS_EN build macro.

module tb_cv32e40p_lce_detector;

  localparam logic [31:0] MARK = 32'h0000006f;
  localparam logic [31:0] BUB  = 32'h00000000;
  localparam logic [31:0] CNT  = 32'h00000013;
`ifdef CV32E40P_LCE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        enable_i;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic        flush_i;
  logic        alarm_clr_i;
  logic        alarm_o;
  logic [1:0]  state_o;
  logic [15:0] marker_cnt_o;
  logic [7:0]  alarm_cnt_o;

  int checks = 0;
  int errors = 0;

  cv32e40p_lce_detector #(.WWDL(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .flush_i       (flush_i),
    .alarm_clr_i   (alarm_clr_i),
    .alarm_o       (alarm_o),
    .state_o       (state_o),
    .marker_cnt_o  (marker_cnt_o),
    .alarm_cnt_o   (alarm_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it, and return 1 time unit after the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic clr);
    instr_valid_i = v;
    instr_i       = ins;
    flush_i       = fl;
    alarm_clr_i   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable_i = 1'b1;
    step(1'b1, CNT, 1'b0, 1'b0);
    step(1'b1, CNT, 1'b0, 1'b0);
    checks++;
    if (alarm_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_alarm: got %0b want 0", alarm_o); end
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", state_o); end
    checks++;
    if (marker_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL reset_marker_cnt: got %0d want 0", marker_cnt_o); end
    checks++;
    if (alarm_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL reset_alarm_cnt: got %0d want 0", alarm_cnt_o); end
    rst = 1'b0;
    enable_i = 1'b0;
    step(1'b0, BUB, 1'b0, 1'b0);
  endtask

  // Enable cycle carries a counted instruction that must not be evaluated,
  // then 100 windows of exactly WWDL counted instructions plus a marker.
  task automatic test_window;
    enable_i = 1'b1;
    step(1'b1, CNT, 1'b0, 1'b0);
    checks++;
    if (state_o !== 2'd1) begin errors++; $display("[TB] FAIL enable_state: got %0d want 1", state_o); end
    for (int w = 0; w < 100; w++) begin
      for (int k = 0; k < 9; k++) begin
        step(1'b1, (k == 8) ? MARK : CNT, 1'b0, 1'b0);
        checks++;
        if (alarm_o !== 1'b0) begin errors++; $display("[TB] FAIL window_alarm w%0d k%0d: got %0b want 0", w, k, alarm_o); end
      end
    end
    checks++;
    if (marker_cnt_o !== (STATS ? 16'd100 : 16'd0)) begin errors++; $display("[TB] FAIL window_marker_cnt: got %0d want %0d", marker_cnt_o, STATS ? 100 : 0); end
    checks++;
    if (alarm_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL window_alarm_cnt: got %0d want 0", alarm_cnt_o); end
  endtask

  task automatic test_violation;
    step(1'b1, MARK, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, CNT, 1'b0, 1'b0);
      checks++;
      if (alarm_o !== 1'b0) begin errors++; $display("[TB] FAIL viol_pre_alarm k%0d: got %0b want 0", k, alarm_o); end
    end
    step(1'b1, CNT, 1'b0, 1'b0);
    checks++;
    if (alarm_o !== 1'b1) begin errors++; $display("[TB] FAIL viol_alarm: got %0b want 1", alarm_o); end
    checks++;
    if (state_o !== 2'd2) begin errors++; $display("[TB] FAIL viol_state: got %0d want 2", state_o); end
    checks++;
    if (alarm_cnt_o !== (STATS ? 8'd1 : 8'd0)) begin errors++; $display("[TB] FAIL viol_alarm_cnt: got %0d want %0d", alarm_cnt_o, STATS ? 1 : 0); end
  endtask

  // ALARM must ignore instructions, flushes, markers and a dropped enable.
  task automatic test_alarm_hold;
    for (int i = 0; i < 20; i++) begin
      enable_i = !(i >= 7 && i <= 9);
      step(1'b1, (i == 10) ? MARK : CNT, (i % 5) == 0, 1'b0);
      checks++;
      if (alarm_o !== 1'b1 || state_o !== 2'd2) begin errors++; $display("[TB] FAIL hold i%0d: got alarm %0b state %0d want 1/2", i, alarm_o, state_o); end
    end
    enable_i = 1'b1;
    step(1'b0, BUB, 1'b0, 1'b1);
    checks++;
    if (state_o !== 2'd1 || alarm_o !== 1'b0) begin errors++; $display("[TB] FAIL clr_to_mon: got state %0d alarm %0b want 1/0", state_o, alarm_o); end
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, CNT, 1'b0, 1'b0);
      checks++;
      if (alarm_o !== 1'b0) begin errors++; $display("[TB] FAIL post_clr_alarm k%0d: got %0b want 0", k, alarm_o); end
    end
    step(1'b1, CNT, 1'b0, 1'b0);
    checks++;
    if (alarm_o !== 1'b1) begin errors++; $display("[TB] FAIL post_clr_viol: got %0b want 1", alarm_o); end
    checks++;
    if (alarm_cnt_o !== (STATS ? 8'd2 : 8'd0)) begin errors++; $display("[TB] FAIL hold_alarm_cnt: got %0d want %0d", alarm_cnt_o, STATS ? 2 : 0); end
  endtask

  // Flush beats a same-cycle counted instruction; alarm_clr_i in MON is inert.
  task automatic test_flush;
    enable_i = 1'b0;
    step(1'b0, BUB, 1'b0, 1'b1);
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("[TB] FAIL clr_to_idle: got %0d want 0", state_o); end
    enable_i = 1'b1;
    step(1'b1, CNT, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) step(1'b1, CNT, 1'b0, 1'b0);
    step(1'b1, CNT, 1'b1, 1'b0);
    checks++;
    if (alarm_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_prio: got %0b want 0", alarm_o); end
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, CNT, 1'b0, k == 4);
      checks++;
      if (alarm_o !== 1'b0) begin errors++; $display("[TB] FAIL after_flush k%0d: got %0b want 0", k, alarm_o); end
    end
    step(1'b1, CNT, 1'b0, 1'b0);
    checks++;
    if (alarm_o !== 1'b1 || state_o !== 2'd2) begin errors++; $display("[TB] FAIL flush_viol: got alarm %0b state %0d want 1/2", alarm_o, state_o); end
    checks++;
    if (alarm_cnt_o !== (STATS ? 8'd3 : 8'd0)) begin errors++; $display("[TB] FAIL flush_alarm_cnt: got %0d want %0d", alarm_cnt_o, STATS ? 3 : 0); end
  endtask

  task automatic test_ignored;
    step(1'b0, BUB, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, CNT, 1'b0, 1'b0);
      checks++;
      if (alarm_o !== (k == 9)) begin errors++; $display("[TB] FAIL ign_alarm k%0d: got %0b want %0b", k, alarm_o, k == 9); end
      if (k < 9) begin
        step(1'b1, BUB, 1'b0, 1'b0);
        step(1'b0, MARK, 1'b0, 1'b0);
        step(1'b0, CNT, 1'b0, 1'b0);
        checks++;
        if (alarm_o !== 1'b0) begin errors++; $display("[TB] FAIL ign_gap k%0d: got %0b want 0", k, alarm_o); end
      end
    end
    step(1'b0, BUB, 1'b0, 1'b1);
    step(1'b1, CNT, 1'b0, 1'b0);
    step(1'b1, CNT, 1'b0, 1'b0);
    enable_i = 1'b0;
    step(1'b1, CNT, 1'b0, 1'b0);
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("[TB] FAIL disable_idle: got %0d want 0", state_o); end
    step(1'b1, CNT, 1'b1, 1'b0);
    enable_i = 1'b1;
    step(1'b1, CNT, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, CNT, 1'b0, 1'b0);
      checks++;
      if (alarm_o !== 1'b0) begin errors++; $display("[TB] FAIL reenable k%0d: got %0b want 0", k, alarm_o); end
    end
    step(1'b1, CNT, 1'b0, 1'b0);
    checks++;
    if (alarm_o !== 1'b1) begin errors++; $display("[TB] FAIL reenable_viol: got %0b want 1", alarm_o); end
    checks++;
    if (alarm_cnt_o !== (STATS ? 8'd5 : 8'd0)) begin errors++; $display("[TB] FAIL ign_alarm_cnt: got %0d want %0d", alarm_cnt_o, STATS ? 5 : 0); end
    checks++;
    if (marker_cnt_o !== (STATS ? 16'd101 : 16'd0)) begin errors++; $display("[TB] FAIL ign_marker_cnt: got %0d want %0d", marker_cnt_o, STATS ? 101 : 0); end
  endtask

  task automatic test_reset_in_alarm;
    rst = 1'b1;
    step(1'b1, CNT, 1'b0, 1'b0);
    checks++;
    if (alarm_o !== 1'b0 || state_o !== 2'd0) begin errors++; $display("[TB] FAIL rst_alarm: got alarm %0b state %0d want 0/0", alarm_o, state_o); end
    checks++;
    if (marker_cnt_o !== 16'd0 || alarm_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL rst_stats: got %0d/%0d want 0/0", marker_cnt_o, alarm_cnt_o); end
    rst = 1'b0;
    enable_i = 1'b0;
    step(1'b0, BUB, 1'b0, 1'b0);
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("[TB] FAIL post_rst_state: got %0d want 0", state_o); end
  endtask

  initial begin
    rst = 1'b1;
    enable_i = 1'b0;
    instr_valid_i = 1'b0;
    instr_i = '0;
    flush_i = 1'b0;
    alarm_clr_i = 1'b0;
    $display("[TB] starting, stats=%0b", STATS);
    test_reset;
    test_window;
    test_violation;
    test_alarm_hold;
    test_flush;
    test_ignored;
    test_reset_in_alarm;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
